// File: rtl/branch_condition_unit.sv
// LEGv8 branch condition evaluator with NZCV flag-hazard stall and a registered taken decision.
// Optional statistics counters are enabled with the BRANCH_COND_STATS_EN macro.
module branch_condition_unit #(
  parameter int WAIT_LIMIT = 15
`ifdef BRANCH_COND_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       eval_req,
  output logic       req_ready,
  input  logic [1:0] br_type,
  input  logic [3:0] cond,
  input  logic       reg_zero,
  input  logic       n_in,
  input  logic       z_in,
  input  logic       c_in,
  input  logic       v_in,
  input  logic       flag_pending,
  input  logic       fwd_valid,
  input  logic       fwd_n,
  input  logic       fwd_z,
  input  logic       fwd_c,
  input  logic       fwd_v,
  output logic       taken,
  output logic       result_valid,
  input  logic       result_ack,
  output logic       wait_err
`ifdef BRANCH_COND_STATS_EN
  ,
  output logic [STAT_W-1:0] eval_count,
  output logic [STAT_W-1:0] taken_count,
  output logic [STAT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [1:0] BR_BCOND = 2'b00;
  localparam logic [1:0] BR_CBZ   = 2'b01;
  localparam logic [1:0] BR_CBNZ  = 2'b10;

  state_e           state_q;
  logic             taken_q, result_valid_q, wait_err_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [1:0]       br_type_q;
  logic [3:0]       cond_q;
  logic             reg_zero_q;

  logic [1:0]       sel_br;
  logic [3:0]       sel_cond;
  logic             sel_rz;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             taken_d;
  logic [CNT_W:0]   wait_cnt_d;
  logic             timeout, needs_wait, go_wait, eval_fire;

  function automatic logic cond_holds(input logic [3:0] c, input logic n, input logic z,
                                      input logic cf, input logic v);
    logic r;
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cf;
      4'b0011: r = !cf;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cf & !z;
      4'b1001: r = !(cf & !z);
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = !(!z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [1:0] bt, input logic [3:0] c, input logic rz,
                                        input logic n, input logic z, input logic cf, input logic v);
    logic r;
    case (bt)
      BR_BCOND: r = cond_holds(c, n, z, cf, v);
      BR_CBZ:   r = rz;
      BR_CBNZ:  r = !rz;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

  // In IDLE the live request fields are evaluated; afterwards only the latched copy counts.
  always_comb begin
    sel_br     = br_type_q;
    sel_cond   = cond_q;
    sel_rz     = reg_zero_q;
    if (state_q == IDLE) begin
      sel_br   = br_type;
      sel_cond = cond;
      sel_rz   = reg_zero;
    end
    flag_n     = fwd_valid ? fwd_n : n_in;
    flag_z     = fwd_valid ? fwd_z : z_in;
    flag_c     = fwd_valid ? fwd_c : c_in;
    flag_v     = fwd_valid ? fwd_v : v_in;
    taken_d    = branch_taken(sel_br, sel_cond, sel_rz, flag_n, flag_z, flag_c, flag_v);
    wait_cnt_d = {1'b0, wait_cnt_q} + (CNT_W + 1)'(1);
    timeout    = (wait_cnt_d >= (CNT_W + 1)'(WAIT_LIMIT));
    needs_wait = (sel_br == BR_BCOND) && !fwd_valid && flag_pending;
    go_wait    = 1'b0;
    eval_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        go_wait   = eval_req && needs_wait;
        eval_fire = eval_req && !needs_wait;
      end
      WAIT:    eval_fire = fwd_valid || !flag_pending || timeout;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      taken_q        <= 1'b0;
      result_valid_q <= 1'b0;
      wait_err_q     <= 1'b0;
      wait_cnt_q     <= '0;
      br_type_q      <= '0;
      cond_q         <= '0;
      reg_zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eval_req) begin
            br_type_q  <= br_type;
            cond_q     <= cond;
            reg_zero_q <= reg_zero;
            if (go_wait) begin
              state_q    <= WAIT;
              wait_cnt_q <= '0;
            end else begin
              taken_q        <= taken_d;
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end
          end
        end
        WAIT: begin
          if (eval_fire) begin
            taken_q        <= taken_d;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
            wait_cnt_q     <= '0;
            if (!fwd_valid && flag_pending) wait_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_d[CNT_W-1:0];
          end
        end
        DONE: begin
          if (result_ack) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign taken        = taken_q;
  assign result_valid = result_valid_q;
  assign wait_err     = wait_err_q;

`ifdef BRANCH_COND_STATS_EN
  // Saturating counters: eval/taken count DONE entries, stall counts cycles spent in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      eval_count   <= '0;
      taken_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (eval_fire && (eval_count != '1)) eval_count <= eval_count + 1'b1;
      if (eval_fire && taken_d && (taken_count != '1)) taken_count <= taken_count + 1'b1;
      if ((state_q == WAIT) && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_condition_unit.sv
// Self-checking bench for branch_condition_unit; expected decisions are queued at request time.
// Statistics outputs are checked only when BRANCH_COND_STATS_EN is defined.
module tb_branch_condition_unit;
  localparam int WAIT_LIMIT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       eval_req = 1'b0;
  logic       req_ready;
  logic [1:0] br_type = 2'b00;
  logic [3:0] cond = 4'b0000;
  logic       reg_zero = 1'b0;
  logic       n_in = 1'b0, z_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
  logic       flag_pending = 1'b0;
  logic       fwd_valid = 1'b0;
  logic       fwd_n = 1'b0, fwd_z = 1'b0, fwd_c = 1'b0, fwd_v = 1'b0;
  logic       taken;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       wait_err;
`ifdef BRANCH_COND_STATS_EN
  logic [31:0] eval_count, taken_count, stall_cycles;
`endif

  int checks = 0;
  int fails = 0;
  bit sb_q[$];

  branch_condition_unit #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .eval_req(eval_req), .req_ready(req_ready),
    .br_type(br_type), .cond(cond), .reg_zero(reg_zero),
    .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .flag_pending(flag_pending), .fwd_valid(fwd_valid),
    .fwd_n(fwd_n), .fwd_z(fwd_z), .fwd_c(fwd_c), .fwd_v(fwd_v),
    .taken(taken), .result_valid(result_valid), .result_ack(result_ack),
    .wait_err(wait_err)
`ifdef BRANCH_COND_STATS_EN
    , .eval_count(eval_count), .taken_count(taken_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference decision: even conditions are base tests, odd ones invert them, 1111 is always taken.
  function automatic bit model_taken(input logic [1:0] bt, input logic [3:0] c, input logic rz,
                                     input logic n, input logic z, input logic cf, input logic v);
    bit base;
    if (bt == 2'b01) return rz;
    if (bt == 2'b10) return !rz;
    if (bt == 2'b11) return 1'b1;
    if (c == 4'b1111) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic drive_req(input logic [1:0] bt, input logic [3:0] c, input logic rz, input bit exp);
    eval_req = 1'b1; br_type = bt; cond = c; reg_zero = rz;
    sb_q.push_back(exp);
    @(negedge clk);
    eval_req = 1'b0;
  endtask

  task automatic ack_result;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic wait_result(input int limit, output int cyc);
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (result_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (taken !== 1'b0) begin fails++; $display("[TB] FAIL reset_taken got=%b exp=0", taken); end
    checks++; if (wait_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_wait_err got=%b exp=0", wait_err); end
    reset = 1'b0;
  endtask

  task automatic test_bcond_eq;
    bit exp;
    n_in = 0; z_in = 1; c_in = 0; v_in = 0; flag_pending = 0; fwd_valid = 0;
    drive_req(2'b00, 4'b0000, 1'b0, model_taken(2'b00, 4'b0000, 1'b0, 0, 1, 0, 0));
    checks++; if (result_valid !== 1'b1) begin fails++; $display("[TB] FAIL eq_latency valid got=%b exp=1", result_valid); end
    checks++;
    if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL eq_taken scoreboard empty"); end
    else begin
      exp = sb_q.pop_front();
      if (taken !== exp) begin fails++; $display("[TB] FAIL eq_taken got=%b exp=%b", taken, exp); end
    end
    // A request during DONE must be ignored and the result held.
    eval_req = 1'b1; br_type = 2'b01; reg_zero = 1'b0; z_in = 0;
    repeat (2) @(negedge clk);
    eval_req = 1'b0;
    checks++; if (result_valid !== 1'b1 || taken !== exp) begin fails++; $display("[TB] FAIL eq_hold valid=%b taken=%b exp valid=1 taken=%b", result_valid, taken, exp); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL done_req_ready got=%b exp=0", req_ready); end
    ack_result();
    checks++; if (req_ready !== 1'b1 || result_valid !== 1'b0) begin fails++; $display("[TB] FAIL eq_ack ready=%b valid=%b exp ready=1 valid=0", req_ready, result_valid); end
  endtask

  task automatic test_forward_wait;
    bit exp;
    n_in = 1; z_in = 0; c_in = 0; v_in = 0; flag_pending = 1;
    fwd_n = 1; fwd_z = 0; fwd_c = 0; fwd_v = 1; fwd_valid = 0;
    drive_req(2'b00, 4'b1010, 1'b0, model_taken(2'b00, 4'b1010, 1'b0, 1, 0, 0, 1));
    cond = 4'b1011;
    checks++; if (result_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL fwd_enter_wait valid=%b ready=%b exp 0/0", result_valid, req_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin fails++; $display("[TB] FAIL fwd_still_wait valid=%b exp=0", result_valid); end
    fwd_valid = 1;
    @(negedge clk);
    fwd_valid = 0;
    checks++; if (result_valid !== 1'b1) begin fails++; $display("[TB] FAIL fwd_valid_out got=%b exp=1", result_valid); end
    checks++;
    if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL fwd_taken scoreboard empty"); end
    else begin
      exp = sb_q.pop_front();
      if (taken !== exp) begin fails++; $display("[TB] FAIL fwd_taken got=%b exp=%b", taken, exp); end
    end
    checks++; if (wait_err !== 1'b0) begin fails++; $display("[TB] FAIL fwd_wait_err got=%b exp=0", wait_err); end
    flag_pending = 0;
    ack_result();
  endtask

  task automatic test_pending_retire;
    bit exp;
    n_in = 0; z_in = 1; c_in = 0; v_in = 0; fwd_n = 0; fwd_z = 0; fwd_c = 0; fwd_v = 0;
    flag_pending = 1; fwd_valid = 0;
    drive_req(2'b00, 4'b0000, 1'b0, model_taken(2'b00, 4'b0000, 1'b0, 0, 1, 0, 0));
    @(negedge clk);
    flag_pending = 0;
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL retire_taken scoreboard empty"); end
    else begin
      exp = sb_q.pop_front();
      if (result_valid !== 1'b1 || taken !== exp) begin fails++; $display("[TB] FAIL retire_taken valid=%b taken=%b exp valid=1 taken=%b", result_valid, taken, exp); end
    end
    ack_result();
    // Pending retires in the same cycle the forward arrives: forwarded flags must win.
    flag_pending = 1;
    drive_req(2'b00, 4'b0000, 1'b0, model_taken(2'b00, 4'b0000, 1'b0, 0, 0, 0, 0));
    flag_pending = 0; fwd_valid = 1;
    @(negedge clk);
    fwd_valid = 0;
    checks++;
    if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL fwd_wins scoreboard empty"); end
    else begin
      exp = sb_q.pop_front();
      if (result_valid !== 1'b1 || taken !== exp) begin fails++; $display("[TB] FAIL fwd_wins valid=%b taken=%b exp valid=1 taken=%b", result_valid, taken, exp); end
    end
    ack_result();
  endtask

  task automatic test_timeout;
    bit exp;
    int cyc;
    n_in = 0; z_in = 0; c_in = 0; v_in = 0; fwd_z = 1; fwd_valid = 0; flag_pending = 1;
    drive_req(2'b00, 4'b1100, 1'b0, model_taken(2'b00, 4'b1100, 1'b0, 0, 0, 0, 0));
    wait_result(40, cyc);
    checks++; if (cyc != WAIT_LIMIT) begin fails++; $display("[TB] FAIL timeout_cycles got=%0d exp=%0d", cyc, WAIT_LIMIT); end
    checks++; if (wait_err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_err got=%b exp=1", wait_err); end
    checks++;
    if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL timeout_taken scoreboard empty"); end
    else begin
      exp = sb_q.pop_front();
      if (taken !== exp) begin fails++; $display("[TB] FAIL timeout_taken got=%b exp=%b", taken, exp); end
    end
    flag_pending = 0; fwd_z = 0;
    ack_result();
    checks++; if (wait_err !== 1'b1) begin fails++; $display("[TB] FAIL err_sticky got=%b exp=1", wait_err); end
  endtask

  task automatic test_compare_branches;
    logic [1:0] bts [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       rzs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit exp;
    n_in = 0; z_in = 0; c_in = 0; v_in = 0;
    flag_pending = 1; fwd_valid = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(bts[i], 4'($urandom_range(0, 15)), rzs[i], model_taken(bts[i], 4'b0000, rzs[i], 0, 0, 0, 0));
      checks++;
      if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL cb_taken scoreboard empty"); end
      else begin
        exp = sb_q.pop_front();
        if (result_valid !== 1'b1 || taken !== exp) begin
          fails++;
          $display("[TB] FAIL cb_taken type=%b rz=%b valid=%b taken=%b exp valid=1 taken=%b", bts[i], rzs[i], result_valid, taken, exp);
        end
      end
      ack_result();
    end
    flag_pending = 0;
  endtask

  task automatic test_sweep;
    logic [3:0] cv, fv;
    bit exp;
    flag_pending = 0; fwd_valid = 0;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        cv = 4'(c); fv = 4'(f);
        {n_in, z_in, c_in, v_in} = fv;
        {fwd_n, fwd_z, fwd_c, fwd_v} = ~fv;
        drive_req(2'b00, cv, 1'b0, model_taken(2'b00, cv, 1'b0, fv[3], fv[2], fv[1], fv[0]));
        checks++;
        if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL sweep scoreboard empty"); end
        else begin
          exp = sb_q.pop_front();
          if (result_valid !== 1'b1 || taken !== exp) begin
            fails++;
            $display("[TB] FAIL sweep cond=%b nzcv=%b valid=%b taken=%b exp valid=1 taken=%b", cv, fv, result_valid, taken, exp);
          end
        end
        ack_result();
      end
    end
    {fwd_n, fwd_z, fwd_c, fwd_v} = 4'b0000;
  endtask

  task automatic test_reset_midop;
    bit exp;
    int cyc;
    n_in = 0; z_in = 0; c_in = 0; v_in = 0; flag_pending = 1; fwd_valid = 0;
    drive_req(2'b00, 4'b0000, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    checks++;
    if (req_ready !== 1'b1 || result_valid !== 1'b0 || wait_err !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_in_wait ready=%b valid=%b err=%b exp 1/0/0", req_ready, result_valid, wait_err);
    end
`ifdef BRANCH_COND_STATS_EN
    checks++;
    if (eval_count !== 0 || taken_count !== 0 || stall_cycles !== 0) begin
      fails++; $display("[TB] FAIL rst_stats eval=%0d taken=%0d stall=%0d exp 0/0/0", eval_count, taken_count, stall_cycles);
    end
`endif
    // The wait counter must restart from zero after a reset taken mid-WAIT.
    drive_req(2'b00, 4'b1110, 1'b0, model_taken(2'b00, 4'b1110, 1'b0, 0, 0, 0, 0));
    wait_result(40, cyc);
    checks++; if (cyc != WAIT_LIMIT || wait_err !== 1'b1) begin fails++; $display("[TB] FAIL rst_cnt_clear cycles=%0d err=%b exp %0d/1", cyc, wait_err, WAIT_LIMIT); end
    checks++;
    if (sb_q.size() == 0) begin fails++; $display("[TB] FAIL rst_al_taken scoreboard empty"); end
    else begin
      exp = sb_q.pop_front();
      if (taken !== exp) begin fails++; $display("[TB] FAIL rst_al_taken got=%b exp=%b", taken, exp); end
    end
    flag_pending = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || result_valid !== 1'b0 || wait_err !== 1'b0 || taken !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_in_done ready=%b valid=%b err=%b taken=%b exp 1/0/0/0", req_ready, result_valid, wait_err, taken);
    end
`ifdef BRANCH_COND_STATS_EN
    checks++;
    if (eval_count !== 0 || taken_count !== 0 || stall_cycles !== 0) begin
      fails++; $display("[TB] FAIL rst_stats_done eval=%0d taken=%0d stall=%0d exp 0/0/0", eval_count, taken_count, stall_cycles);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_bcond_eq();
    test_forward_wait();
    test_pending_retire();
    test_timeout();
    test_compare_branches();
    test_sweep();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/branch_condition_unit.md
Name: branch_condition_unit

Overview:
- Consumer side of the NZCV status flags.
- Evaluates the LEGv8 branch condition for B.cond, CBZ, CBNZ and B, and returns a registered taken/not-taken decision to the PC-select logic.
- Resolves flag hazards. If a flag-setting instruction has not yet committed, the unit stalls until forwarded ALU flags arrive or the pending update retires.

Parameters:
- WAIT_LIMIT, 15: maximum cycles spent in WAIT before an error is flagged.
- STAT_W, 32: width of the statistics counters; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- eval_req  in  1  evaluation request; accepted when req_ready=1
- req_ready  out  1  high in IDLE only
- br_type  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional)
- cond  in  4  LEGv8 condition field; used for B.cond only
- reg_zero  in  1  Rt==0 indication; used for CBZ/CBNZ
- n_in, z_in, c_in, v_in  in  1 each  committed flags
- flag_pending  in  1  an older flag-setting instruction is uncommitted
- fwd_valid  in  1  forwarded ALU flags valid this cycle
- fwd_n, fwd_z, fwd_c, fwd_v  in  1 each  forwarded flags
- taken  out  1  branch decision
- result_valid  out  1  taken is valid
- result_ack  in  1  consumer accepts the result
- wait_err  out  1  sticky WAIT timeout flag

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
  - Reset forces state IDLE, taken=0, result_valid=0, wait_err=0 and wait counter=0.
  - Reset mid-operation discards any in-flight request.
- States: IDLE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On eval_req, br_type, cond and reg_zero are latched.
  - Flag selection for B.cond:
    - fwd_valid=1: use the fwd_* flags.
    - fwd_valid=0 and flag_pending=1: go to WAIT.
    - Otherwise: use the *_in flags.
  - For CBZ, CBNZ and B, no flags are needed, so the unit never waits.
  - On evaluation: taken is registered and the unit goes to DONE; result_valid=1 on the next cycle, so latency is 1 cycle.
- WAIT:
  - Counter increments each cycle.
  - fwd_valid=1: evaluate with fwd_* flags and go to DONE.
  - Else flag_pending=0: evaluate with *_in flags and go to DONE.
  - Else counter reaches WAIT_LIMIT: set wait_err=1, evaluate with *_in flags and go to DONE.
  - Counter clears on leaving WAIT.
- DONE:
  - result_valid=1 and taken are held stable until result_ack=1; the unit then returns to IDLE.
  - req_ready=0, so eval_req is ignored.
  - result_ack in IDLE or WAIT has no effect.
- Condition table for B.cond:

| cond | mnemonic | taken when |
|---|---|---|
| 0000 | EQ | Z |
| 0001 | NE | !Z |
| 0010 | HS | C |
| 0011 | LO | !C |
| 0100 | MI | N |
| 0101 | PL | !N |
| 0110 | VS | V |
| 0111 | VC | !V |
| 1000 | HI | C&!Z |
| 1001 | LS | !(C&!Z) |
| 1010 | GE | N==V |
| 1011 | LT | N!=V |
| 1100 | GT | !Z&(N==V) |
| 1101 | LE | !(!Z&(N==V)) |
| 1110 | AL | 1 |
| 1111 | NV | 1 (always, per ARMv8) |

- Other branch types: CBZ taken=reg_zero; CBNZ taken=!reg_zero; B taken=1.
- Simultaneous events:
  - fwd_valid and flag_pending=0 in the same cycle: forwarded flags win.
  - Only the latched request fields are used after IDLE; input changes are ignored.
- wait_err is cleared only by reset.

Optional Feature:
- Macro: BRANCH_COND_STATS_EN.
- When defined:
  - Adds outputs eval_count[STAT_W-1:0], taken_count[STAT_W-1:0] and stall_cycles[STAT_W-1:0].
  - Counters increment, respectively, on each DONE entry, on each DONE entry with taken=1, and on each WAIT cycle.
  - All counters saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then B.cond cond=0000 with z_in=1 and flag_pending=0 → result_valid=1 and taken=1 one cycle after accept; hold until ack, then req_ready=1.
- B.cond cond=1010 with N=1, V=0 committed and flag_pending=1; fwd_valid with fwd_n=1, fwd_v=1 three cycles later → WAIT for 3 cycles, then taken=1 (forwarded GE).
- B.cond cond=1100 with flag_pending held high and no forward, WAIT_LIMIT=15 → wait_err=1 after 15 WAIT cycles; taken computed from *_in.
- CBZ with reg_zero=1 and flag_pending=1 → no WAIT, taken=1; CBNZ with reg_zero=1 → taken=0.
- Sweep all 16 cond values over all 16 NZCV combinations with no pending flags → taken matches the table in 256/256 cases; 1110 and 1111 are always 1.
- Assert reset while in WAIT and again in DONE → next cycle IDLE, result_valid=0, wait_err=0; with BRANCH_COND_STATS_EN, all counters read 0.
